// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result bundle for the bit-serial subtractor.
//   start, a, b, bin : request side, driven by the master
//   busy, done       : progress/handshake, driven by the slave
//   diff, bout, ovf  : held result, driven by the slave
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b - bin one bit per clock, LSB first,
// through one full-subtractor cell with a registered borrow.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_subtractor_if
//           start/a/b/bin sampled only on the accepting edge (IDLE or DONE);
//           busy high in RUN, done a one-cycle pulse in DONE;
//           diff/bout/ovf update only on entry to DONE and hold otherwise.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, a_msb_q, b_msb_q, bout_q, ovf_q;

  // Full-subtractor cell on the current LSBs.
  logic             d_bit, br_d;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    d_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    res_d = {d_bit, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            br_q    <= bus.bin;
            res_q   <= '0;
            cnt_q   <= '0;
            // Operands are shifted away, so keep the sign bits for overflow.
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            ovf_q   <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] last_diff;   // value diff must hold until the next done

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int r;
    logic [7:0] d;
    logic bo, ov;
    r  = int'(a) - int'(b) - int'(bin);
    d  = r[7:0];
    bo = (r < 0);
    ov = (a[7] != b[7]) && (d[7] != a[7]);
    return {bo, ov, d};
  endfunction

  // Waits (bounded) for done, counting negedges and busy cycles; checks
  // busy/done exclusivity and that diff holds its old value until done.
  task automatic wait_done(output int cyc, output int nbusy);
    cyc = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.busy) nbusy++;
      chk("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
      if (!bus.done) chk("diff_hold", 32'(bus.diff), 32'(last_diff));
    end while (!bus.done && cyc < 30);
    if (!bus.done) chk("timeout_done", 32'd0, 32'd1);
  endtask

  // Called at a negedge with the block in IDLE or DONE; returns at the
  // negedge where done is observed.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input string tag, input logic chk_lat);
    logic [9:0] e;
    int cyc, nb;
    e = ref_sub(a, b, bin);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.a = ~a; bus.b = 8'($urandom); bus.bin = ~bin;
    wait_done(cyc, nb);
    if (chk_lat) begin
      chk({tag, "_lat"},  32'(cyc), 32'd9);
      chk({tag, "_busy"}, 32'(nb),  32'd8);
    end
    chk({tag, "_diff"}, 32'(bus.diff), 32'(e[7:0]));
    chk({tag, "_bout"}, 32'(bus.bout), 32'(e[9]));
    chk({tag, "_ovf"},  32'(bus.ovf),  32'(e[8]));
    last_diff = e[7:0];
  endtask

  initial begin
    logic [9:0] e;
    int cyc, nb;
    logic [7:0] ra, rb;
    logic rbin;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    last_diff = 8'h00;
    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    chk("rst_ovf",  32'(bus.ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(8'h05, 8'h03, 1'b0, "d05_03", 1'b1);
    @(negedge clk);
    chk("done_pulse_one", 32'(bus.done), 32'd0);
    chk("idle_hold", 32'(bus.diff), 32'h02);
    do_op(8'h03, 8'h05, 1'b0, "d03_05", 1'b1);
    @(negedge clk);
    do_op(8'h00, 8'h00, 1'b1, "d00_00b", 1'b1);
    @(negedge clk);
    do_op(8'h80, 8'h01, 1'b0, "d80_01", 1'b1);
    @(negedge clk);
    do_op(8'h7F, 8'hFF, 1'b0, "d7F_FF", 1'b1);

    // Back-to-back: start held during DONE is accepted with no gap.
    do_op(8'hA5, 8'h3C, 1'b1, "b2b", 1'b1);

    // start pulsed during RUN is ignored.
    @(negedge clk);
    e = ref_sub(8'h44, 8'h11, 1'b0);
    bus.start = 1'b1; bus.a = 8'h44; bus.b = 8'h11; bus.bin = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'hF0; bus.bin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, nb);
    chk("ign_lat",  32'(cyc), 32'd5);
    chk("ign_diff", 32'(bus.diff), 32'(e[7:0]));
    chk("ign_bout", 32'(bus.bout), 32'(e[9]));
    chk("ign_ovf",  32'(bus.ovf),  32'(e[8]));
    last_diff = e[7:0];
    @(negedge clk);
    chk("ign_no_second", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-RUN after four bits.
    bus.start = 1'b1; bus.a = 8'hC3; bus.b = 8'h5A; bus.bin = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_diff", 32'(bus.diff), 32'd0);
    chk("arst_bout", 32'(bus.bout), 32'd0);
    chk("arst_ovf",  32'(bus.ovf),  32'd0);
    last_diff = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("arst_no_done", 32'(bus.done | bus.busy), 32'd0);
    end
    do_op(8'h5A, 8'hC3, 1'b1, "post_rst", 1'b1);

    // Random operations, mixing idle gaps and back-to-back issue.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end
      do_op(ra, rb, rbin, "rnd", 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing A − B − Bin, LSB first, one bit per clock, through a single full-subtractor cell with a registered borrow. It complements the combinational full-adder path in the arithmetic library by trading area for latency. Operands are accepted with a start/busy/done handshake, and results are held until the next operation is accepted.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal values are WIDTH ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an operation; sampled on the rising edge.
- a  input  WIDTH  minuend; sampled only on the accepting edge.
- b  input  WIDTH  subtrahend; sampled only on the accepting edge.
- bin  input  1  borrow-in; sampled only on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  result bits, equal to (a − b − bin) mod 2^WIDTH.
- bout  output  1  final borrow-out; 1 when the unsigned result of a − b − bin is negative.
- ovf  output  1  two's-complement overflow of the signed subtraction.

## Operation
- States:
  - IDLE: ready to accept an operation.
  - RUN: processing bits.
  - DONE: result presented; lasts exactly one cycle.
- Accept rule: start=1 at an edge while the block is in IDLE or DONE.
  - On acceptance, latch a, b and bin into internal shift registers and the borrow register, clear the bit counter, and enter RUN.
- start in RUN is ignored. No re-latch, no error.
- RUN, per edge, operating on the current LSBs ai and bi and the borrow register br:
  - d = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - Shift d into the result register from the MSB side.
  - Shift the a and b registers right by one bit.
  - Increment the counter.
- After the WIDTH-th RUN edge, enter DONE.
  - Register bout = final br.
  - Register ovf = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1]), computed from the latched original operand MSBs.
- DONE to IDLE on the next edge, unless start=1, in which case the new operation is accepted (back-to-back).
- diff, bout and ovf are updated only on entry to DONE.
  - They hold their value through the following IDLE and RUN periods until the next DONE.
  - Intermediate shift contents are never visible on diff.
- busy = 1 exactly in RUN. done = 1 exactly in DONE.
- Counter width is clog2(WIDTH+1). The counter never wraps within an operation.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; internal registers cleared.
- Reset deassertion is synchronised externally. The first edge with rst_n=1 may accept start.
- Reset asserted mid-RUN aborts the operation immediately. No done pulse is produced and outputs return to 0.
- Latency, with start accepted at edge 0:
  - busy is high from after edge 0 through edge WIDTH.
  - done is high for the one cycle following edge WIDTH, with diff, bout and ovf valid in that same cycle.
- Throughput: one operation per WIDTH+1 cycles when issued back-to-back on done.
- Inputs a, b and bin may change freely after the accepting edge.
- busy and done are never high in the same cycle.

## Test plan
All scenarios use WIDTH=8.
- a=0x05, b=0x03, bin=0 → done exactly 9 cycles after the start edge; diff=0x02, bout=0, ovf=0; busy high for 8 cycles.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, ovf=0. a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1. a=0x7F, b=0xFF, bin=0 → diff=0x80, bout=1, ovf=1.
- start pulsed at RUN cycle 3 with different operands → ignored; the first result completes unchanged. start held high during DONE → second operation accepted; its done follows 9 cycles later with no idle gap.
- rst_n pulled low asynchronously mid-RUN at bit 4 → busy, done, diff, bout and ovf are 0 immediately; no done pulse appears after reset release; a fresh start then produces a correct result.
- Random self-check of 1000 operand/bin triples against the reference model (a − b − bin) → diff, bout and ovf match on every done pulse.
